// File: rtl/layer_seq.sv
// layer_seq: programmable layer sequencer.
//
// Walks a host-loaded stage table. Each entry names one of NUM_ENG layer
// engines or ends the sequence (opcode all-ones). The selected engine is
// enabled while the registered DRAM-ready flag is high. Its DRAM bus is muxed
// onto the shared DRAM port.
//
// Ports:
//   clk, srstn          clock, synchronous active-low reset
//   start               pulse, run the table from stage 0 (ignored while busy)
//   cfg_we/addr/op      stage table write port (ignored while busy)
//   rdy_data            DRAM data ready (registered before use)
//   eng_*  (inputs)     per-engine done pulses and flattened DRAM buses
//   eng_en              one-hot enable of the running engine
//   data_out, addr_in, addr_out, dram_en_wr, dram_en_rd
//                       DRAM bus of the running engine, zero otherwise
//   busy, done, err     sequencer status
//   done_one_layer      one-cycle pulse per completed stage
//   stage_idx           current stage index
//   perf_last           cycle count of the last completed stage
//
// Optional build macro SEQ_PERF_EN enables the per-stage cycle counter;
// without it perf_last is tied to zero.
module layer_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int NUM_ENG    = 4,
  parameter int MAX_STAGES = 16,
  parameter int OP_W       = 3
) (
  input  logic                            clk,
  input  logic                            srstn,
  input  logic                            start,
  input  logic                            cfg_we,
  input  logic [$clog2(MAX_STAGES)-1:0]   cfg_addr,
  input  logic [OP_W-1:0]                 cfg_op,
  input  logic                            rdy_data,
  input  logic [NUM_ENG-1:0]              eng_done,
  input  logic [NUM_ENG*DATA_WIDTH-1:0]   eng_data_out,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0]   eng_addr_in,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0]   eng_addr_out,
  input  logic [NUM_ENG-1:0]              eng_wr,
  input  logic [NUM_ENG-1:0]              eng_rd,
  output logic [NUM_ENG-1:0]              eng_en,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic [ADDR_WIDTH-1:0]           addr_in,
  output logic [ADDR_WIDTH-1:0]           addr_out,
  output logic                            dram_en_wr,
  output logic                            dram_en_rd,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic                            done_one_layer,
  output logic [$clog2(MAX_STAGES):0]     stage_idx,
  output logic [31:0]                     perf_last
);

  localparam int IW = $clog2(MAX_STAGES);
  localparam logic [OP_W-1:0] OP_END     = '1;
  localparam logic [IW:0]     STAGE_END  = MAX_STAGES[IW:0];
  localparam logic [IW:0]     STAGE_ONE  = {{IW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RUN, S_DONE, S_ERR} state_t;

  state_t          state;
  logic [OP_W-1:0] tbl [MAX_STAGES];
  logic [OP_W-1:0] cur_eng;
  logic [OP_W-1:0] fetch_op;
  logic            rdy_data_ff;
  logic            in_run;
  logic            sel_done;

  // When stage_idx has run off the end of the table this read wraps to
  // entry 0, but the FETCH decode checks the end condition first.
  assign fetch_op = tbl[stage_idx[IW-1:0]];
  assign in_run   = (state == S_RUN);

  assign busy = (state == S_FETCH) || (state == S_RUN);
  assign done = (state == S_DONE);
  assign err  = (state == S_ERR);

  // Engine select: a for-loop mux keeps the index widths exact. It also
  // forces every DRAM output and enable to zero outside RUN.
  always_comb begin
    eng_en     = '0;
    data_out   = '0;
    addr_in    = '0;
    addr_out   = '0;
    dram_en_wr = 1'b0;
    dram_en_rd = 1'b0;
    sel_done   = 1'b0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (in_run && (cur_eng == OP_W'(i))) begin
        eng_en[i]  = rdy_data_ff;
        data_out   = eng_data_out[i*DATA_WIDTH +: DATA_WIDTH];
        addr_in    = eng_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        addr_out   = eng_addr_out[i*ADDR_WIDTH +: ADDR_WIDTH];
        dram_en_wr = eng_wr[i];
        dram_en_rd = eng_rd[i];
        sel_done   = eng_done[i];
      end
    end
  end

  // Sequencer FSM and stage table. The table is writable only while the
  // sequencer is idle, so a running sequence always sees a stable program.
  // A write together with start commits first, and FETCH then reads the new
  // entry.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      state          <= S_IDLE;
      stage_idx      <= '0;
      cur_eng        <= '0;
      rdy_data_ff    <= 1'b0;
      done_one_layer <= 1'b0;
      for (int i = 0; i < MAX_STAGES; i++) tbl[i] <= OP_END;
    end else begin
      rdy_data_ff    <= rdy_data;
      done_one_layer <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (cfg_we) tbl[cfg_addr] <= cfg_op;
          if (start) begin
            state     <= S_FETCH;
            stage_idx <= '0;
          end
        end
        S_FETCH: begin
          if (stage_idx == STAGE_END) begin
            state <= S_DONE;
          end else if (32'(fetch_op) < NUM_ENG) begin
            cur_eng <= fetch_op;
            state   <= S_RUN;
          end else if (fetch_op == OP_END) begin
            state <= S_DONE;
          end else begin
            state <= S_ERR;
          end
        end
        S_RUN: begin
          if (sel_done) begin
            stage_idx      <= stage_idx + STAGE_ONE;
            done_one_layer <= 1'b1;
            state          <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_PERF_EN
  logic [31:0] perf_cnt;

  // The counter is only read in RUN, so clearing it in every FETCH cycle
  // gives the same result as clearing it on the FETCH->RUN transition.
  // perf_last captures count+1 so that the done cycle itself is included.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      perf_cnt  <= '0;
      perf_last <= '0;
    end else begin
      if (state == S_FETCH) begin
        perf_cnt <= '0;
      end else if (in_run && (perf_cnt != '1)) begin
        perf_cnt <= perf_cnt + 32'd1;
      end
      if (in_run && sel_done) begin
        perf_last <= (perf_cnt == '1) ? perf_cnt : perf_cnt + 32'd1;
      end
    end
  end
`else
  assign perf_last = '0;
`endif

endmodule

// File: tb/tb_layer_seq.sv
// tb_layer_seq: self-checking bench for layer_seq.
// A table-walk reference model predicts the engine order, the pulse count and
// the final stage and status for each run. Directed tasks cover latency,
// gating, reset and performance-counter behaviour.
module tb_layer_seq;

  localparam int DW = 32;
  localparam int AW = 18;
  localparam int NE = 4;
  localparam int MS = 16;
  localparam int OW = 3;
  localparam int IW = 4;
  localparam int OP_END = 7;

  logic            clk = 1'b0;
  logic            srstn = 1'b0;
  logic            start = 1'b0;
  logic            cfg_we = 1'b0;
  logic [IW-1:0]   cfg_addr = '0;
  logic [OW-1:0]   cfg_op = '0;
  logic            rdy_data = 1'b0;
  logic [NE-1:0]   eng_done = '0;
  logic [NE*DW-1:0] eng_data_out = '0;
  logic [NE*AW-1:0] eng_addr_in = '0;
  logic [NE*AW-1:0] eng_addr_out = '0;
  logic [NE-1:0]   eng_wr = '0;
  logic [NE-1:0]   eng_rd = '0;
  logic [NE-1:0]   eng_en;
  logic [DW-1:0]   data_out;
  logic [AW-1:0]   addr_in;
  logic [AW-1:0]   addr_out;
  logic            dram_en_wr;
  logic            dram_en_rd;
  logic            busy;
  logic            done;
  logic            err;
  logic            done_one_layer;
  logic [IW:0]     stage_idx;
  logic [31:0]     perf_last;

  int checks = 0;
  int errors = 0;

  int mdl_tbl [MS];
  int exp_order[$];
  int exp_stage;
  bit exp_err;
  int obs_order[$];
  int obs_pulses;
  int first_en;

  logic [DW-1:0] bus_d  [NE];
  logic [AW-1:0] bus_ai [NE];
  logic [AW-1:0] bus_ao [NE];

  layer_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE), .MAX_STAGES(MS), .OP_W(OW)) dut (
    .clk(clk), .srstn(srstn), .start(start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_op(cfg_op), .rdy_data(rdy_data), .eng_done(eng_done), .eng_data_out(eng_data_out),
    .eng_addr_in(eng_addr_in), .eng_addr_out(eng_addr_out), .eng_wr(eng_wr), .eng_rd(eng_rd),
    .eng_en(eng_en), .data_out(data_out), .addr_in(addr_in), .addr_out(addr_out),
    .dram_en_wr(dram_en_wr), .dram_en_rd(dram_en_rd), .busy(busy), .done(done), .err(err),
    .done_one_layer(done_one_layer), .stage_idx(stage_idx), .perf_last(perf_last)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    srstn = 1'b0;
    tick();
    tick();
    srstn = 1'b1;
    for (int i = 0; i < MS; i++) mdl_tbl[i] = OP_END;
  endtask

  task automatic write_entry(input int addr, input int op);
    cfg_addr = IW'(addr);
    cfg_op   = OW'(op);
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
    mdl_tbl[addr] = op;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic randomize_buses();
    for (int i = 0; i < NE; i++) begin
      bus_d[i]  = $urandom;
      bus_ai[i] = AW'($urandom);
      bus_ao[i] = AW'($urandom);
      eng_data_out[i*DW +: DW] = bus_d[i];
      eng_addr_in[i*AW +: AW]  = bus_ai[i];
      eng_addr_out[i*AW +: AW] = bus_ao[i];
    end
    eng_wr = NE'($urandom);
    eng_rd = NE'($urandom);
  endtask

  // Reference model: walk the table as the host would describe it.
  task automatic model_run();
    int i;
    i = 0;
    exp_order.delete();
    exp_err = 1'b0;
    while (i < MS) begin
      if (mdl_tbl[i] < NE) begin
        exp_order.push_back(mdl_tbl[i]);
        i++;
      end else begin
        exp_err = (mdl_tbl[i] != OP_END);
        break;
      end
    end
    exp_stage = i;
  endtask

  function automatic bit order_ok();
    if (obs_order.size() != exp_order.size()) return 1'b0;
    foreach (obs_order[i]) if (obs_order[i] != exp_order[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Behavioural engines: respond to eng_en with a done pulse lat cycles later.
  // Also checks that the enable is one-hot and that the DRAM mux shows the
  // active engine's bus. With noisy set, rdy_data, foreign done pulses,
  // start and cfg_we are randomised while the sequencer is busy.
  task automatic run_engines(input int lat, input bit noisy, input int we_at);
    int active;
    int cnt;
    bit fin;
    active = -1;
    cnt = 0;
    fin = 1'b0;
    obs_order.delete();
    obs_pulses = 0;
    first_en = -1;
    for (int c = 1; c <= 3000 && !fin; c++) begin
      tick();
      eng_done = '0;
      start = 1'b0;
      cfg_we = 1'b0;
      if (noisy) rdy_data = ($urandom_range(0, 3) != 0);
      if (done_one_layer) obs_pulses++;
      if (done || err) begin
        fin = 1'b1;
      end else begin
        if (active < 0 && eng_en != '0) begin
          for (int i = NE - 1; i >= 0; i--) if (eng_en[i]) active = i;
          if (first_en < 0) first_en = c;
          obs_order.push_back(active);
          cnt = 0;
          checks++;
          if (!$onehot(eng_en) || data_out !== bus_d[active] || addr_in !== bus_ai[active] ||
              addr_out !== bus_ao[active] || dram_en_wr !== eng_wr[active] || dram_en_rd !== eng_rd[active]) begin
            errors++;
            $display("[TB] FAIL mux_sel eng_en=%b data_out=%h expected engine %0d data %h", eng_en, data_out, active, bus_d[active]);
          end
        end
        if (c == we_at) begin
          cfg_we = 1'b1;
          cfg_addr = 4'd3;
          cfg_op = 3'd7;
        end
        if (active >= 0) begin
          if (noisy) begin
            eng_done = NE'($urandom) & ~(NE'(1) << active);
            if ($urandom_range(0, 7) == 0) start = 1'b1;
            if ($urandom_range(0, 5) == 0) begin
              cfg_we = 1'b1;
              cfg_addr = IW'($urandom);
              cfg_op = OW'($urandom);
            end
          end
          cnt++;
          if (cnt >= lat) begin
            eng_done[active] = 1'b1;
            active = -1;
          end
        end
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("[TB] FAIL run_timeout busy=%b stage_idx=%0d, required done or err within budget", busy, stage_idx);
    end
    eng_done = '0;
    start = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({busy, done, err, done_one_layer} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_status got %b required 0000", {busy, done, err, done_one_layer});
    end
    checks++;
    if (stage_idx !== '0 || eng_en !== '0 || perf_last !== '0) begin
      errors++;
      $display("[TB] FAIL reset_regs stage=%0d eng_en=%b perf=%0d required all 0", stage_idx, eng_en, perf_last);
    end
    checks++;
    if (data_out !== '0 || addr_in !== '0 || addr_out !== '0 || dram_en_wr !== 1'b0 || dram_en_rd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_dram data=%h ai=%h ao=%h required 0", data_out, addr_in, addr_out);
    end
  endtask

  task automatic test_empty();
    rdy_data = 1'b1;
    randomize_buses();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || eng_en !== '0) begin
      errors++;
      $display("[TB] FAIL empty_fetch busy=%b done=%b eng_en=%b required 1 0 0", busy, done, eng_en);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || stage_idx !== 5'd0) begin
      errors++;
      $display("[TB] FAIL empty_done done=%b busy=%b stage=%0d required 1 0 0", done, busy, stage_idx);
    end
    checks++;
    if (eng_en !== '0 || done_one_layer !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_quiet eng_en=%b pulse=%b required 0", eng_en, done_one_layer);
    end
  endtask

  task automatic test_table_seq();
    for (int i = 0; i < 6; i++) write_entry(i, i % 3);
    rdy_data = 1'b1;
    randomize_buses();
    pulse_start();
    run_engines(10, 1'b0, -1);
    model_run();
    checks++;
    if (!order_ok()) begin
      errors++;
      $display("[TB] FAIL seq_order got %0d stages required %0d in table order", obs_order.size(), exp_order.size());
    end
    checks++;
    if (obs_pulses != 6 || stage_idx !== 5'd6 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL seq_end pulses=%0d stage=%0d done=%b required 6 6 1", obs_pulses, stage_idx, done);
    end
    checks++;
    if (first_en != 1) begin
      errors++;
      $display("[TB] FAIL seq_latency first eng_en at %0d cycles after FETCH, required 1", first_en);
    end
    checks++;
    if (eng_en !== '0 || data_out !== '0 || addr_out !== '0 || dram_en_wr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL seq_idle_bus eng_en=%b data=%h required 0", eng_en, data_out);
    end
  endtask

  task automatic test_rdy_gate();
    apply_reset();
    write_entry(0, 1);
    rdy_data = 1'b1;
    pulse_start();
    tick();
    checks++;
    if (eng_en !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL gate_on eng_en=%b required 0010", eng_en);
    end
    rdy_data = 1'b0;
    tick();
    checks++;
    if (eng_en !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL gate_off eng_en=%b required 0000", eng_en);
    end
    eng_done = 4'b0100;
    tick();
    eng_done = '0;
    tick();
    checks++;
    if (busy !== 1'b1 || stage_idx !== 5'd0 || done_one_layer !== 1'b0) begin
      errors++;
      $display("[TB] FAIL foreign_done busy=%b stage=%0d pulse=%b required 1 0 0", busy, stage_idx, done_one_layer);
    end
    rdy_data = 1'b1;
    tick();
    eng_done = 4'b0010;
    tick();
    eng_done = '0;
    checks++;
    if (done_one_layer !== 1'b1 || stage_idx !== 5'd1) begin
      errors++;
      $display("[TB] FAIL own_done pulse=%b stage=%0d required 1 1", done_one_layer, stage_idx);
    end
    tick();
    checks++;
    if (done !== 1'b1 || done_one_layer !== 1'b0) begin
      errors++;
      $display("[TB] FAIL own_done_end done=%b pulse=%b required 1 0", done, done_one_layer);
    end
  endtask

  task automatic test_err();
    apply_reset();
    write_entry(0, 0);
    write_entry(1, 5);
    rdy_data = 1'b1;
    pulse_start();
    run_engines(3, 1'b0, -1);
    model_run();
    checks++;
    if (err !== exp_err || done !== 1'b0 || stage_idx !== 5'(exp_stage) || obs_pulses != exp_order.size()) begin
      errors++;
      $display("[TB] FAIL err_stop err=%b stage=%0d pulses=%0d required 1 %0d %0d", err, stage_idx, obs_pulses, exp_stage, exp_order.size());
    end
    pulse_start();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_clear err=%b busy=%b required 0 1", err, busy);
    end
    run_engines(2, 1'b0, -1);
    checks++;
    if (err !== 1'b1 || stage_idx !== 5'd1) begin
      errors++;
      $display("[TB] FAIL err_again err=%b stage=%0d required 1 1", err, stage_idx);
    end
  endtask

  task automatic test_full_table();
    apply_reset();
    for (int i = 0; i < MS; i++) write_entry(i, 0);
    rdy_data = 1'b1;
    pulse_start();
    run_engines(2, 1'b0, 4);
    model_run();
    checks++;
    if (!order_ok() || obs_pulses != 16 || stage_idx !== 5'd16 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_run stages=%0d pulses=%0d stage=%0d done=%b required 16 16 16 1", obs_order.size(), obs_pulses, stage_idx, done);
    end
    pulse_start();
    run_engines(1, 1'b0, -1);
    checks++;
    if (obs_pulses != 16 || stage_idx !== 5'd16 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_rerun pulses=%0d stage=%0d required 16 16 (table must be unchanged)", obs_pulses, stage_idx);
    end
    cfg_addr = 4'd0;
    cfg_op = 3'd7;
    cfg_we = 1'b1;
    start = 1'b1;
    tick();
    cfg_we = 1'b0;
    start = 1'b0;
    mdl_tbl[0] = OP_END;
    tick();
    checks++;
    if (done !== 1'b1 || stage_idx !== 5'd0 || eng_en !== '0) begin
      errors++;
      $display("[TB] FAIL we_with_start done=%b stage=%0d eng_en=%b required 1 0 0", done, stage_idx, eng_en);
    end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    write_entry(0, 1);
    write_entry(1, 2);
    rdy_data = 1'b1;
    randomize_buses();
    pulse_start();
    tick();
    tick();
    eng_done = 4'b0010;
    srstn = 1'b0;
    tick();
    eng_done = '0;
    srstn = 1'b1;
    for (int i = 0; i < MS; i++) mdl_tbl[i] = OP_END;
    checks++;
    if ({busy, done, err, done_one_layer} !== 4'b0000 || stage_idx !== '0 || perf_last !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_reset status=%b stage=%0d perf=%0d required 0", {busy, done, err, done_one_layer}, stage_idx, perf_last);
    end
    checks++;
    if (eng_en !== '0 || data_out !== '0 || addr_in !== '0 || dram_en_rd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_bus eng_en=%b data=%h required 0", eng_en, data_out);
    end
    tick();
    checks++;
    if (done_one_layer !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_pulse pulse=%b required 0", done_one_layer);
    end
    pulse_start();
    tick();
    checks++;
    if (done !== 1'b1 || stage_idx !== 5'd0) begin
      errors++;
      $display("[TB] FAIL midrun_table_clear done=%b stage=%0d required 1 0", done, stage_idx);
    end
  endtask

  task automatic test_perf();
    int lat;
    int exp_perf;
    apply_reset();
    write_entry(0, 2);
    write_entry(1, 2);
    rdy_data = 1'b1;
    pulse_start();
    tick();
    repeat (6) tick();
    eng_done = 4'b0100;
    tick();
    eng_done = '0;
`ifdef SEQ_PERF_EN
    exp_perf = 7;
`else
    exp_perf = 0;
`endif
    checks++;
    if (perf_last !== 32'(exp_perf) || done_one_layer !== 1'b1) begin
      errors++;
      $display("[TB] FAIL perf_seven perf_last=%0d pulse=%b required %0d 1", perf_last, done_one_layer, exp_perf);
    end
    lat = $urandom_range(1, 20);
    tick();
    repeat (lat - 1) tick();
    eng_done = 4'b0100;
    tick();
    eng_done = '0;
`ifdef SEQ_PERF_EN
    exp_perf = lat;
`else
    exp_perf = 0;
`endif
    checks++;
    if (perf_last !== 32'(exp_perf)) begin
      errors++;
      $display("[TB] FAIL perf_rand perf_last=%0d required %0d", perf_last, exp_perf);
    end
    tick();
    checks++;
    if (done !== 1'b1 || stage_idx !== 5'd2) begin
      errors++;
      $display("[TB] FAIL perf_end done=%b stage=%0d required 1 2", done, stage_idx);
    end
  endtask

  task automatic test_random();
    int k;
    int op;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < MS; i++) begin
        k = $urandom_range(0, 9);
        if (k < 7) op = $urandom_range(0, NE - 1);
        else if (k < 9) op = OP_END;
        else op = $urandom_range(NE, OP_END - 1);
        write_entry(i, op);
      end
      rdy_data = 1'b1;
      randomize_buses();
      pulse_start();
      run_engines($urandom_range(1, 6), 1'b1, -1);
      model_run();
      checks++;
      if (!order_ok() || obs_pulses != exp_order.size()) begin
        errors++;
        $display("[TB] FAIL rand_order it=%0d stages=%0d pulses=%0d required %0d", it, obs_order.size(), obs_pulses, exp_order.size());
      end
      checks++;
      if (stage_idx !== 5'(exp_stage) || err !== exp_err || done !== !exp_err) begin
        errors++;
        $display("[TB] FAIL rand_end it=%0d stage=%0d err=%b done=%b required %0d %b %b", it, stage_idx, err, done, exp_stage, exp_err, !exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_table_seq();
    test_rdy_gate();
    test_err();
    test_full_table();
    test_reset_mid_run();
    test_perf();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
